fifo_level: RTL and testbench

Parametrised synchronous FIFO with first-word-fall-through read data, an occupancy counter, programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, and a synchronous clear. It is the standard buffering block between the UART receiver/transmitter and their host-side logic. Its extra flags let producers throttle early and let software detect lost or spurious transfers.

---
 rtl/fifo_level.sv | 119 +++++++++++
 tb/tb_fifo_level.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_level.sv
// First-word-fall-through FIFO with an occupancy counter, programmable almost-full/almost-empty
// flags, sticky overflow/underflow error flags and a synchronous clear.
module fifo_level #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int LW    = ADDR_WIDTH + 1;

   localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
   localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_THRESH);
   localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] storage_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wPtr_q, wPtr_d;
   logic [ADDR_WIDTH-1:0] rPtr_q, rPtr_d;
   logic [LW-1:0]         level_q, level_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic rdAccept;
   logic wrAccept;

   // A write into a full FIFO is still legal when a read frees the slot in the same cycle.
   always_comb begin
      rdAccept = rd && (level_q != '0);
      wrAccept = wr && ((level_q != DEPTH_L) || rdAccept);
   end

   // Next-state: clear wins over every request and suppresses error flagging.
   always_comb begin
      wPtr_d      = wPtr_q;
      rPtr_d      = rPtr_q;
      level_d     = level_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (clr) begin
         wPtr_d      = '0;
         rPtr_d      = '0;
         level_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wrAccept) begin
            wPtr_d = wPtr_q + 1'b1;
         end
         if (rdAccept) begin
            rPtr_d = rPtr_q + 1'b1;
         end
         case ({wrAccept, rdAccept})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
         if (wr && !wrAccept) begin
            overflow_d = 1'b1;
         end
         if (rd && !rdAccept) begin
            underflow_d = 1'b1;
         end
      end
   end

   // Control state register; async reset returns everything to the empty state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wPtr_q      <= '0;
         rPtr_q      <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wPtr_q      <= wPtr_d;
         rPtr_q      <= rPtr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage has no reset so it can map onto plain RAM; clear leaves the contents in place.
   always_ff @(posedge clk) begin
      if (wrAccept && !clr) begin
         storage_q[wPtr_q] <= w_data;
      end
   end

   // Flags decode from the level register only, so no request input reaches them combinationally.
   always_comb begin
      r_data       = storage_q[rPtr_q];
      level        = level_q;
      full         = (level_q == DEPTH_L);
      empty        = (level_q == '0);
      almost_full  = (level_q >= AFULL_L);
      almost_empty = (level_q <= AEMPTY_L);
      overflow     = overflow_q;
      underflow    = underflow_q;
   end

endmodule

// File: tb/tb_fifo_level.sv
// Directed self-checking bench for fifo_level at default parameters (8-bit data, 16 entries,
// almost-full at 12, almost-empty at 2).
module tb_fifo_level;

   logic       clk;
   logic       reset;
   logic       clr;
   logic       wr;
   logic [7:0] wData;
   logic       rd;
   logic [7:0] rData;
   logic       full;
   logic       empty;
   logic       almostFull;
   logic       almostEmpty;
   logic [4:0] level;
   logic       overflow;
   logic       underflow;

   int checkCount = 0;
   int passCount  = 0;

   fifo_level dut (
      .clk          (clk),
      .reset        (reset),
      .clr          (clr),
      .wr           (wr),
      .w_data       (wData),
      .rd           (rd),
      .r_data       (rData),
      .full         (full),
      .empty        (empty),
      .almost_full  (almostFull),
      .almost_empty (almostEmpty),
      .level        (level),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of requests, then leave the bench 1 unit after the rising edge with inputs idle.
   task automatic applyStimulus(input logic w, input logic r, input logic c, input logic [7:0] d);
      wr    = w;
      rd    = r;
      clr   = c;
      wData = d;
      @(posedge clk);
      #1;
      wr    = 1'b0;
      rd    = 1'b0;
      clr   = 1'b0;
      wData = 8'h00;
   endtask

   initial begin
      reset = 1'b1;
      clr   = 1'b0;
      wr    = 1'b0;
      rd    = 1'b0;
      wData = 8'h00;
      repeat (2) @(posedge clk);
      #1;

      // Reset state.
      checkOutput("rst level", 32'(level), 0);
      checkOutput("rst empty", 32'(empty), 1);
      checkOutput("rst full", 32'(full), 0);
      checkOutput("rst aempty", 32'(almostEmpty), 1);
      checkOutput("rst afull", 32'(almostFull), 0);
      checkOutput("rst overflow", 32'(overflow), 0);
      checkOutput("rst underflow", 32'(underflow), 0);
      reset = 1'b0;
      applyStimulus(0, 0, 0, 8'h00);

      // Fill with 0x00..0x0F.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1, 0, 0, 8'(i));
         checkOutput("fill level", 32'(level), 32'(i + 1));
         checkOutput("fill afull", 32'(almostFull), (i + 1 >= 12) ? 1 : 0);
         checkOutput("fill head", 32'(rData), 0);
      end
      checkOutput("fill full", 32'(full), 1);

      // Overflow on full.
      applyStimulus(1, 0, 0, 8'hAA);
      checkOutput("ovf flag", 32'(overflow), 1);
      checkOutput("ovf level", 32'(level), 16);

      // Drain; 0xAA must never appear.
      for (int i = 0; i < 16; i++) begin
         checkOutput("drain data", 32'(rData), 32'(i));
         applyStimulus(0, 1, 0, 8'h00);
         checkOutput("drain aempty", 32'(almostEmpty), (15 - i <= 2) ? 1 : 0);
      end
      checkOutput("drain empty", 32'(empty), 1);
      checkOutput("drain underflow", 32'(underflow), 0);

      // Underflow on empty.
      applyStimulus(0, 1, 0, 8'h00);
      checkOutput("udf flag", 32'(underflow), 1);
      checkOutput("udf level", 32'(level), 0);

      // Clear, then simultaneous request on empty.
      applyStimulus(0, 0, 1, 8'h00);
      checkOutput("clr overflow", 32'(overflow), 0);
      checkOutput("clr underflow", 32'(underflow), 0);
      applyStimulus(1, 1, 0, 8'h55);
      checkOutput("simE level", 32'(level), 1);
      checkOutput("simE data", 32'(rData), 32'h55);
      checkOutput("simE underflow", 32'(underflow), 1);
      applyStimulus(0, 1, 0, 8'h00);
      checkOutput("simE empty", 32'(empty), 1);
      applyStimulus(0, 0, 1, 8'h00);

      // Simultaneous request on full replaces the oldest word in order.
      for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 8'(i));
      applyStimulus(1, 1, 0, 8'h10);
      checkOutput("simF level", 32'(level), 16);
      checkOutput("simF full", 32'(full), 1);
      checkOutput("simF overflow", 32'(overflow), 0);
      for (int i = 0; i < 16; i++) begin
         checkOutput("simF data", 32'(rData), 32'(i + 1));
         applyStimulus(0, 1, 0, 8'h00);
      end
      checkOutput("simF empty", 32'(empty), 1);

      // Streaming at level 5 across two pointer wraps.
      applyStimulus(0, 0, 1, 8'h00);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 8'(i));
      for (int i = 0; i < 40; i++) begin
         checkOutput("stream data", 32'(rData), 32'(i));
         applyStimulus(1, 1, 0, 8'(i + 5));
         checkOutput("stream level", 32'(level), 5);
      end
      checkOutput("stream overflow", 32'(overflow), 0);
      checkOutput("stream underflow", 32'(underflow), 0);
      checkOutput("stream afull", 32'(almostFull), 0);
      checkOutput("stream aempty", 32'(almostEmpty), 0);

      // Clear together with write at level 7 with overflow set.
      applyStimulus(0, 0, 1, 8'h00);
      for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 8'(i));
      applyStimulus(1, 0, 0, 8'hEE);
      for (int i = 0; i < 9; i++) applyStimulus(0, 1, 0, 8'h00);
      checkOutput("mid level", 32'(level), 7);
      checkOutput("mid overflow", 32'(overflow), 1);
      checkOutput("mid data", 32'(rData), 9);
      applyStimulus(1, 0, 1, 8'h77);
      checkOutput("clrwr level", 32'(level), 0);
      checkOutput("clrwr empty", 32'(empty), 1);
      checkOutput("clrwr overflow", 32'(overflow), 0);

      // Asynchronous reset between edges.
      applyStimulus(0, 1, 0, 8'h00);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 8'(i + 8'h30));
      checkOutput("pre-rst level", 32'(level), 3);
      checkOutput("pre-rst underflow", 32'(underflow), 1);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("async level", 32'(level), 0);
      checkOutput("async empty", 32'(empty), 1);
      checkOutput("async aempty", 32'(almostEmpty), 1);
      checkOutput("async underflow", 32'(underflow), 0);
      #2;
      reset = 1'b0;
      applyStimulus(0, 0, 0, 8'h00);
      checkOutput("post-rst level", 32'(level), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
